// File: rtl/tap_pkg.sv
// Shared JTAG TAP types: IEEE 1149.1 state encoding, host command op codes, sequencer phases.
package tap_pkg;

  typedef enum logic [3:0] {
    TapTlr,
    TapRti,
    TapSelDr,
    TapCapDr,
    TapShiftDr,
    TapExit1Dr,
    TapPauseDr,
    TapExit2Dr,
    TapUpdateDr,
    TapSelIr,
    TapCapIr,
    TapShiftIr,
    TapExit1Ir,
    TapPauseIr,
    TapExit2Ir,
    TapUpdateIr
  } tap_state_t;

  typedef enum logic [1:0] {
    OpReset   = 2'd0,
    OpShiftIr = 2'd1,
    OpShiftDr = 2'd2,
    OpNop     = 2'd3
  } tap_op_t;

  typedef enum logic [2:0] {
    PhInit,
    PhIdle,
    PhReset,
    PhNav,
    PhShift,
    PhExit
  } seq_phase_t;

  // Number of TMS=1 cycles that force any TAP into Test-Logic-Reset.
  localparam int unsigned InitTmsOnes = 5;

endpackage

// File: rtl/tap_state_mirror.sv
// Tracks the 16-state IEEE 1149.1 TAP FSM from the TMS value driven on each rising edge.
module tap_state_mirror
  import tap_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TapTlr:      state_d = tms_i ? TapTlr      : TapRti;
      TapRti:      state_d = tms_i ? TapSelDr    : TapRti;
      TapSelDr:    state_d = tms_i ? TapSelIr    : TapCapDr;
      TapCapDr:    state_d = tms_i ? TapExit1Dr  : TapShiftDr;
      TapShiftDr:  state_d = tms_i ? TapExit1Dr  : TapShiftDr;
      TapExit1Dr:  state_d = tms_i ? TapUpdateDr : TapPauseDr;
      TapPauseDr:  state_d = tms_i ? TapExit2Dr  : TapPauseDr;
      TapExit2Dr:  state_d = tms_i ? TapUpdateDr : TapShiftDr;
      TapUpdateDr: state_d = tms_i ? TapSelDr    : TapRti;
      TapSelIr:    state_d = tms_i ? TapTlr      : TapCapIr;
      TapCapIr:    state_d = tms_i ? TapExit1Ir  : TapShiftIr;
      TapShiftIr:  state_d = tms_i ? TapExit1Ir  : TapShiftIr;
      TapExit1Ir:  state_d = tms_i ? TapUpdateIr : TapPauseIr;
      TapPauseIr:  state_d = tms_i ? TapExit2Ir  : TapPauseIr;
      TapExit2Ir:  state_d = tms_i ? TapUpdateIr : TapShiftIr;
      TapUpdateIr: state_d = tms_i ? TapSelDr    : TapRti;
      default:     state_d = TapTlr;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TapTlr;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_master.sv
// Host-side JTAG TAP driver: turns RESET/SHIFT_IR/SHIFT_DR/NOP commands into TMS/TDI pad sequences.
// Define TAP_MASTER_CAPTURE_EN to build the TDO capture register; otherwise rsp_data is tied to 0.
module tap_master
  import tap_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               GCLK_Pad,
  input  logic               RST_Pad,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TMS_Pad,
  output logic               TDI_Pad,
  input  logic               TDO_Pad
);

  seq_phase_t         phase_q, phase_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic               is_ir_q, is_ir_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               accept;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   nav_last;
  tap_state_t         tap_state;

  tap_state_mirror u_mirror (
    .clk_i   (GCLK_Pad),
    .rst_i   (RST_Pad),
    .tms_i   (tms_q),
    .state_o (tap_state)
  );

  assign cmd_ready   = (phase_q == PhIdle) && (tap_state == TapRti);
  assign accept      = cmd_valid && cmd_ready;
  assign len_clamped = (cmd_len == '0)               ? LEN_W'(1) :
                       (cmd_len > LEN_W'(MAX_LEN))   ? LEN_W'(MAX_LEN) : cmd_len;
  // IR navigation is 1,1,0,0 (four bits); DR navigation is 1,0,0 (three bits).
  assign nav_last    = is_ir_q ? LEN_W'(3) : LEN_W'(2);

  // tms_q/tdi_q always hold the bit of position cnt_q within phase_q.
  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    data_d      = data_q;
    is_ir_d     = is_ir_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    rsp_valid_d = 1'b0;

    case (phase_q)
      PhInit, PhReset: begin
        if (cnt_q < LEN_W'(InitTmsOnes)) begin
          cnt_d = cnt_q + LEN_W'(1);
          tms_d = (cnt_d < LEN_W'(InitTmsOnes));
        end else begin
          phase_d     = PhIdle;
          cnt_d       = '0;
          rsp_valid_d = (phase_q == PhReset);
        end
      end
      PhIdle: begin
        if (accept) begin
          cnt_d  = '0;
          len_d  = len_clamped;
          data_d = cmd_data;
          unique case (tap_op_t'(cmd_op))
            OpReset: begin
              phase_d = PhReset;
              tms_d   = 1'b1;
            end
            OpShiftIr: begin
              phase_d = PhNav;
              is_ir_d = 1'b1;
              tms_d   = 1'b1;
            end
            OpShiftDr: begin
              phase_d = PhNav;
              is_ir_d = 1'b0;
              tms_d   = 1'b1;
            end
            OpNop: begin
              rsp_valid_d = 1'b1;
            end
          endcase
        end
      end
      PhNav: begin
        if (cnt_q < nav_last) begin
          cnt_d = cnt_q + LEN_W'(1);
          tms_d = is_ir_q ? (cnt_d < LEN_W'(2)) : 1'b0;
        end else begin
          phase_d = PhShift;
          cnt_d   = '0;
          tms_d   = (len_q == LEN_W'(1));
          tdi_d   = data_q[0];
          data_d  = data_q >> 1;
        end
      end
      PhShift: begin
        if (cnt_q != len_q - LEN_W'(1)) begin
          cnt_d  = cnt_q + LEN_W'(1);
          tms_d  = (cnt_d == len_q - LEN_W'(1));
          tdi_d  = data_q[0];
          data_d = data_q >> 1;
        end else begin
          phase_d = PhExit;
          cnt_d   = '0;
          tms_d   = 1'b1;
        end
      end
      PhExit: begin
        if (cnt_q == '0) begin
          cnt_d = LEN_W'(1);
        end else begin
          phase_d     = PhIdle;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        phase_d = PhInit;
        cnt_d   = '0;
        tms_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      phase_q     <= PhInit;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      data_q      <= '0;
      is_ir_q     <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_q      <= data_d;
      is_ir_q     <= is_ir_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef TAP_MASTER_CAPTURE_EN
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  // TDO is sampled on the edge that ends each cycle spent in Shift-xR.
  always_comb begin
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      cap_d = '0;
    end else if (tap_state == TapShiftIr || tap_state == TapShiftDr) begin
      cap_d = cap_q | ({{(MAX_LEN - 1){1'b0}}, TDO_Pad} << cnt_q);
    end
    if (rsp_valid_d) begin
      rsp_data_d = (phase_q == PhExit) ? cap_q : '0;
    end
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      cap_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_data = rsp_data_q;
`else
  logic unused_tdo;
  assign unused_tdo = TDO_Pad;
  assign rsp_data   = '0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign TMS_Pad   = tms_q;
  assign TDI_Pad   = tdi_q;

endmodule

// File: tb/tb_tap_master.sv
// Directed bench for tap_master; the target side is modelled as TDO = TDI (loop) or TDO = ~TDI.
module tb_tap_master;
  import tap_pkg::*;

  logic        GCLK_Pad  = 1'b0;
  logic        RST_Pad   = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op    = 2'd3;
  logic [5:0]  cmd_len   = 6'd0;
  logic [31:0] cmd_data  = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TMS_Pad;
  logic        TDI_Pad;
  logic        TDO_Pad;
  logic        tdo_loop  = 1'b1;
  tap_state_t  tb_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 GCLK_Pad = ~GCLK_Pad;

  assign TDO_Pad = tdo_loop ? TDI_Pad : ~TDI_Pad;

  tap_master #(
    .MAX_LEN (32),
    .LEN_W   (6)
  ) u_dut (
    .GCLK_Pad  (GCLK_Pad),
    .RST_Pad   (RST_Pad),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .TMS_Pad   (TMS_Pad),
    .TDI_Pad   (TDI_Pad),
    .TDO_Pad   (TDO_Pad)
  );

  tap_state_mirror u_tb_mirror (
    .clk_i   (GCLK_Pad),
    .rst_i   (RST_Pad),
    .tms_i   (TMS_Pad),
    .state_o (tb_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cap(input logic [31:0] v);
`ifdef TAP_MASTER_CAPTURE_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  // Releases reset at a falling edge and watches cycles 1..7 of the init sequence.
  task automatic init_check(input string tag);
    logic [5:0] tms_seq;
    logic [6:0] rdy_seq;
    int         rsp_seen;
    tms_seq  = '0;
    rdy_seq  = '0;
    rsp_seen = 0;
    RST_Pad  = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (c <= 6) tms_seq[c-1] = TMS_Pad;
      rdy_seq[c-1] = cmd_ready;
      if (rsp_valid) rsp_seen++;
      @(negedge GCLK_Pad);
    end
    check_eq({tag, "_tms"}, 64'(tms_seq), 64'h1f);
    check_eq({tag, "_ready"}, 64'(rdy_seq), 64'h40);
    check_eq({tag, "_no_rsp"}, 64'(rsp_seen), 64'd0);
    check_eq({tag, "_state"}, 64'(tb_state), 64'(TapRti));
  endtask

  // Issues one command at a falling edge; cycle j is the cycle after acceptance edge k+j.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input int ncyc, input logic [39:0] exp_tms,
                         input logic [39:0] exp_tdi, input logic [31:0] exp_rsp);
    logic [39:0] tms_seq;
    logic [39:0] tdi_seq;
    int          busy_err;
    int          wait_n;
    tms_seq  = '0;
    tdi_seq  = '0;
    busy_err = 0;
    wait_n   = 0;
    while (!cmd_ready && wait_n < 100) begin
      @(negedge GCLK_Pad);
      wait_n++;
    end
    check_eq({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge GCLK_Pad);
    cmd_valid = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      tms_seq[j] = TMS_Pad;
      tdi_seq[j] = TDI_Pad;
      if (rsp_valid || cmd_ready) busy_err++;
      @(negedge GCLK_Pad);
    end
    check_eq({tag, "_tms"}, 64'(tms_seq), 64'(exp_tms));
    check_eq({tag, "_tdi"}, 64'(tdi_seq), 64'(exp_tdi));
    check_eq({tag, "_busy"}, 64'(busy_err), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    check_eq({tag, "_state"}, 64'(tb_state), 64'(TapRti));
  endtask

  initial begin
    logic [39:0] tms_seq;
    logic [39:0] tdi_seq;
    logic        rsp_at6;
    logic        rdy_at6;
    logic        rsp_at13;
    int          rsp_seen;

    repeat (3) @(negedge GCLK_Pad);
    check_eq("rst_tms", 64'(TMS_Pad), 64'd1);
    check_eq("rst_tdi", 64'(TDI_Pad), 64'd0);
    check_eq("rst_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("rst_state", 64'(tb_state), 64'(TapTlr));

    init_check("init");

    // IR len 4, data 0xA, target returns ~TDI: TMS 1,1,0,0,0,0,0,1,1,0.
    tdo_loop = 1'b0;
    run_cmd("ir4", 2'd1, 6'd4, 32'hA, 10, 40'h183, 40'hA0, cap(32'h5));
    tdo_loop = 1'b1;

    // DR len 32 looped back: nav 1,0,0; shift cycles j3..j34; exit j35,j36.
    run_cmd("dr32", 2'd2, 6'd32, 32'hDEADBEEF, 37, 40'h0C_0000_0001,
            40'h6_F56D_F778, cap(32'hDEADBEEF));

    run_cmd("reset", 2'd0, 6'd0, 32'h0, 6, 40'h1F, 40'h0, 32'h0);
    run_cmd("nop", 2'd3, 6'd5, 32'hFFFF_FFFF, 0, 40'h0, 40'h0, 32'h0);

    // len 0 clamps to 1 bit; len 40 clamps to 32 bits.
    run_cmd("len0", 2'd2, 6'd0, 32'h3, 6, 40'h19, 40'h8, cap(32'h1));
    run_cmd("len40", 2'd2, 6'd40, 32'h12345678, 37, 40'h0C_0000_0001,
            40'h0_91A2_B3C0, cap(32'h12345678));

    // Back-to-back: DR len 1 then RESET with cmd_valid held throughout.
    tms_seq  = '0;
    tdi_seq  = '0;
    rsp_seen = 0;
    check_eq("b2b_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_len   = 6'd1;
    cmd_data  = 32'h1;
    @(negedge GCLK_Pad);
    cmd_op = 2'd0;
    rsp_at6 = 1'b0;
    rdy_at6 = 1'b0;
    for (int j = 0; j < 13; j++) begin
      tms_seq[j] = TMS_Pad;
      tdi_seq[j] = TDI_Pad;
      if (j == 6) begin
        rsp_at6 = rsp_valid;
        rdy_at6 = cmd_ready;
        check_eq("b2b_dr_rsp_data", 64'(rsp_data), 64'(cap(32'h1)));
      end else if (rsp_valid) begin
        rsp_seen++;
      end
      @(negedge GCLK_Pad);
      if (j == 6) cmd_valid = 1'b0;
    end
    rsp_at13 = rsp_valid;
    check_eq("b2b_rsp6", 64'(rsp_at6), 64'd1);
    check_eq("b2b_rdy6", 64'(rdy_at6), 64'd1);
    check_eq("b2b_tms", 64'(tms_seq), 64'hF99);
    check_eq("b2b_tdi", 64'(tdi_seq), 64'h8);
    check_eq("b2b_stray_rsp", 64'(rsp_seen), 64'd0);
    check_eq("b2b_rsp13", 64'(rsp_at13), 64'd1);
    check_eq("b2b_rsp13_data", 64'(rsp_data), 64'd0);

    // Reset asserted in shift cycle 1 (cycle 5) of an IR shift of 0xFF.
    check_eq("mid_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_len   = 6'd8;
    cmd_data  = 32'hFF;
    @(negedge GCLK_Pad);
    cmd_valid = 1'b0;
    repeat (5) @(negedge GCLK_Pad);
    check_eq("mid_tdi_before", 64'(TDI_Pad), 64'd1);
    check_eq("mid_state_before", 64'(tb_state), 64'(TapShiftIr));
    RST_Pad = 1'b1;
    #1;
    check_eq("mid_tms", 64'(TMS_Pad), 64'd1);
    check_eq("mid_tdi", 64'(TDI_Pad), 64'd0);
    check_eq("mid_ready_rst", 64'(cmd_ready), 64'd0);
    check_eq("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rsp_data", 64'(rsp_data), 64'd0);
    rsp_seen = 0;
    repeat (3) begin
      @(negedge GCLK_Pad);
      if (rsp_valid) rsp_seen++;
    end
    check_eq("mid_no_rsp", 64'(rsp_seen), 64'd0);
    init_check("reinit");

    tdo_loop = 1'b0;
    run_cmd("ir4_after", 2'd1, 6'd4, 32'h3, 10, 40'h183, 40'h30, cap(32'hC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tap_master.md
# tap_master

Host-side JTAG TAP driver: the initiator that sits across the pad interface from the on-chip `TAP_route` TAP controller. It turns single-word commands into TMS/TDI pad sequences, clocked by the same `GCLK_Pad`. Supported commands are TAP reset, IR shift and DR shift. It captures TDO during shifts and returns the captured word. It is used in system-level benches and on the bring-up board to drive the TAP without hand-written TMS waveforms.

## Interface
Parameters:
- `MAX_LEN`, 32, maximum shift length in bits.
- `LEN_W`, `$clog2(MAX_LEN+1)`, width of the length field.

Ports:
- `GCLK_Pad` in 1: single clock; all flops on the rising edge.
- `RST_Pad` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on an edge where valid and ready are both 1.
- `cmd_op` in 2: 0 = RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = NOP (accepted, no pad activity).
- `cmd_len` in `LEN_W`: number of shift bits.
- `cmd_data` in `MAX_LEN`: TDI bits, shifted out LSB first.
- `rsp_valid` out 1: one-cycle pulse; there is no backpressure on the response.
- `rsp_data` out `MAX_LEN`: captured TDO, right-aligned; bit i holds the TDO sample from shift cycle i; unused bits are 0.
- `TMS_Pad` out 1: registered test mode select.
- `TDI_Pad` out 1: registered test data in.
- `TDO_Pad` in 1: test data out from the target.

## Operation
- An internal mirror of the 16-state IEEE 1149.1 TAP FSM is advanced on every edge by the TMS value being driven. The master only issues commands from Run-Test/Idle (RTI).
- **Init:** after reset release, drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle, which lands in RTI.
  - `cmd_ready` rises in the cycle after the RTI entry edge.
- **RESET command:** TMS sequence 1,1,1,1,1,0. Ends in RTI.
- **SHIFT_IR command:**
  - Navigation: TMS 1,1,0,0 (SelDR, SelIR, CapIR, ShiftIR).
  - N shift cycles: TMS=0 on cycles 0..N-2 and TMS=1 on cycle N-1 (Exit1-IR).
  - Exit: TMS 1,0 (Update-IR, RTI).
- **SHIFT_DR command:** navigation TMS 1,0,0, then the same shift and exit phases as SHIFT_IR.
- **TDI:**
  - During shift cycle i, `TDI_Pad` = `cmd_data[i]`.
  - Outside shift cycles, `TDI_Pad` = 0.
- **Length:**
  - `cmd_len` is latched at acceptance.
  - A value of 0 is clamped to 1.
  - A value greater than `MAX_LEN` is clamped to `MAX_LEN`.
  - The shift counter is `LEN_W` bits wide and counts up from 0 to N-1 with no wrap.
- **`cmd_ready`:** 1 only while the FSM is in RTI and idle, including the cycle where `rsp_valid` is high, so commands can run back-to-back. It is 0 from the acceptance edge until the command completes.
- **`rsp_valid`:**
  - SHIFT commands: pulses in the cycle after the RTI return edge.
  - RESET and NOP: pulses with `rsp_data`=0.
- **Reset mid-command:** all state clears immediately and the Init sequence restarts. No `rsp_valid` is produced for the aborted command.
- **Command held while not ready:** ignored until `cmd_ready`=1. No queuing.

## Timing
- Reset values: `TMS_Pad`=1, `TDI_Pad`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, mirror state = Test-Logic-Reset.
- Acceptance at edge k puts the first TMS of the sequence on the pad from edge k to edge k+1.
- SHIFT_IR occupies N+6 pad cycles; SHIFT_DR occupies N+5; RESET occupies 6; NOP occupies 0, with `rsp_valid` in the cycle after edge k.
- `rsp_valid` for a shift asserts in the cycle following edge k+(N+6) for IR or edge k+(N+5) for DR.
- `TDO_Pad` is sampled on the rising edge that ends each shift cycle, i.e. the cycle in which the mirror state is Shift-xR. Exactly N samples are taken.

## Configuration
- `TAP_MASTER_CAPTURE_EN`
  - Defined: the TDO capture register is present and `rsp_data` is as specified above.
  - Undefined: there is no capture logic, `TDO_Pad` is unused, and `rsp_data` is tied to 0. `rsp_valid` timing is unchanged.

## Structure
- Package `tap_pkg`:
  - `tap_state_t`: 16-state enum, shared with TAP-side RTL and benches.
  - `tap_op_t`: op codes.
  - Init length constant: 5 TMS=1 cycles.
- Sub-module `tap_state_mirror`: takes TMS, outputs `tap_state_t`, uses the same asynchronous reset. The sequencer compares its output against the expected states, and the bench reuses it.

## Test plan
- Reset release with no command → `TMS_Pad` is 1,1,1,1,1,0; `cmd_ready` rises on cycle 7; mirror state = RTI.
- SHIFT_IR, len=4, data=0xA → TMS 1,1,0,0,0,0,0,1,1,0; TDI 1010 (LSB first) on cycles 4–7; `rsp_valid` one cycle after cycle 10; `rsp_data` equals the 4 TDO samples.
- SHIFT_DR, len=32, data=0xDEADBEEF, target looped TDI→TDO → `rsp_data`=0xDEADBEEF, 37 pad cycles.
- Back-to-back: `cmd_valid` held with SHIFT_DR len=1, followed by RESET → second command accepted in the `rsp_valid` cycle; RESET TMS = 1,1,1,1,1,0.
- len=0 and len=40 → shift 1 and 32 bits respectively.
- `RST_Pad` asserted mid-shift on cycle 5 → outputs return to reset values immediately, no `rsp_valid`, and the Init sequence reruns.
